exibidor_sequencia: RTL and testbench

- Presentation side of the Genius memory game: plays the stored sequence back on the LEDs so the player can see it before repeating it on the buttons.
- Reads the sequence memory (same synchronous memory the comparison datapath uses) from address 0 up to `limite`.
- Shows each entry for a fixed on-time followed by a blank gap, then pulses `pronto`.
- Sits beside the game control unit: the unit pulses `iniciar` before each round and waits for `pronto` before accepting plays.

---
 rtl/exibidor_sequencia.sv | 118 +++++++++++
 tb/tb_exibidor_sequencia.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exibidor_sequencia.sv
// Sequence playback for the Genius game: walks the sequence memory from address 0
// to the latched limit, showing each word on the LEDs followed by a dark gap.
module exibidor_sequencia #(
    parameter int T_ACESO   = 4,
    parameter int T_APAGADO = 2,
    parameter int ADDR_W    = 4,
    parameter int LED_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [LED_W-1:0]  dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [LED_W-1:0]  leds,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ESPERA  = 4'd2,
        MOSTRA  = 4'd3,
        APAGA   = 4'd4,
        PROXIMO = 4'd5,
        FIM     = 4'd6
    } estado_t;

    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TMR_W-1:0] ULT_ACESO   = TMR_W'(T_ACESO - 1);
    localparam logic [TMR_W-1:0] ULT_APAGADO = TMR_W'(T_APAGADO - 1);

    estado_t           estado_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic [ADDR_W-1:0] limite_reg;

    assign db_estado = estado_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg <= INICIAL;
            timer_reg  <= '0;
            limite_reg <= '0;
            endereco   <= '0;
            leds       <= '0;
            pronto     <= 1'b0;
        end else if (cancelar) begin
            // Abort wins over every transition, including the FIM pulse.
            estado_reg <= INICIAL;
            timer_reg  <= '0;
            endereco   <= '0;
            leds       <= '0;
            pronto     <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado_reg)
                INICIAL: begin
                    leds <= '0;
                    if (iniciar) begin
                        estado_reg <= PREPARA;
                        endereco   <= '0;
                        timer_reg  <= '0;
                    end
                end
                PREPARA: begin
                    // Address 0 is already on the bus, so the read lands in ESPERA.
                    limite_reg <= limite;
                    timer_reg  <= '0;
                    estado_reg <= ESPERA;
                end
                ESPERA: begin
                    leds       <= dado_memoria;
                    timer_reg  <= '0;
                    estado_reg <= MOSTRA;
                end
                MOSTRA: begin
                    if (timer_reg == ULT_ACESO) begin
                        leds       <= '0;
                        timer_reg  <= '0;
                        estado_reg <= APAGA;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                APAGA: begin
                    if (timer_reg == ULT_APAGADO) begin
                        timer_reg <= '0;
                        // The limit compare exits before the address could wrap.
                        if (endereco == limite_reg) begin
                            estado_reg <= FIM;
                            pronto     <= 1'b1;
                        end else begin
                            estado_reg <= PROXIMO;
                            endereco   <= endereco + ADDR_W'(1);
                        end
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                PROXIMO: begin
                    estado_reg <= ESPERA;
                end
                FIM: begin
                    estado_reg <= INICIAL;
                end
                default: begin
                    estado_reg <= INICIAL;
                    timer_reg  <= '0;
                    leds       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Bench for exibidor_sequencia: two instances (default timing and 1/1 timing) share
// stimulus; an edge-counting playback model predicts every output each cycle.
module tb_exibidor_sequencia;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       cancelar;
    logic [3:0] limite;
    logic [3:0] mem [16];

    logic [3:0] dado_a, dado_b, end_a, end_b, leds_a, leds_b, db_a, db_b;
    logic       pronto_a, pronto_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    exibidor_sequencia dut_a (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
        .limite(limite), .dado_memoria(dado_a), .endereco(end_a), .leds(leds_a),
        .pronto(pronto_a), .db_estado(db_a)
    );

    exibidor_sequencia #(.T_ACESO(1), .T_APAGADO(1)) dut_b (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
        .limite(limite), .dado_memoria(dado_b), .endereco(end_b), .leds(leds_b),
        .pronto(pronto_b), .db_estado(db_b)
    );

    // Synchronous sequence memory, one per instance, same contents.
    always @(posedge clock) begin
        dado_a <= mem[end_a];
        dado_b <= mem[end_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- playback model ----------------
    // Playback is described by k = rising edges since the edge that sampled iniciar.
    bit playing [2];
    int k       [2];
    int len     [2];
    int last_ad [2];

    function automatic int ta_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int tg_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    always @(posedge clock or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                playing[d] <= 1'b0;
                k[d]       <= 0;
                last_ad[d] <= 0;
            end else if (cancelar) begin
                playing[d] <= 1'b0;
                last_ad[d] <= 0;
            end else if (!playing[d]) begin
                if (iniciar) begin
                    playing[d] <= 1'b1;
                    k[d]       <= 0;
                    last_ad[d] <= 0;
                end
            end else begin
                if (k[d] == 0) len[d] <= int'(limite) + 1;
                if (k[d] > 0 && k[d] == len[d] * (ta_of(d) + tg_of(d) + 2)) begin
                    playing[d] <= 1'b0;
                    last_ad[d] <= len[d] - 1;
                end else begin
                    k[d] <= k[d] + 1;
                end
            end
        end
    end

    // Each entry takes one period p = wait + on + off + advance, counted from edge 1.
    function automatic void expect_out(input bit pl, input int kk, input int l, input int a,
                                       input int g, input int la, output int st, output int ad,
                                       output int idx, output int pr);
        int off, p, i, r;
        st = 0; ad = la; idx = -1; pr = 0;
        if (pl) begin
            if (kk == 0) begin
                st = 1; ad = 0;
            end else begin
                off = kk - 1; p = a + g + 2; i = off / p; r = off % p; ad = i;
                if (r == 0)            st = 2;
                else if (r <= a)       begin st = 3; idx = i; end
                else if (r <= a + g)   st = 4;
                else if (i == l - 1)   begin st = 6; pr = 1; end
                else                   begin st = 5; ad = i + 1; end
            end
        end
    endfunction

    task automatic compare_one(input int d, input logic [3:0] st, input logic [3:0] ad,
                               input logic [3:0] ld, input logic pr);
        int e_st, e_ad, e_idx, e_pr;
        logic [3:0] e_ld;
        expect_out(playing[d], k[d], len[d], ta_of(d), tg_of(d), last_ad[d], e_st, e_ad, e_idx, e_pr);
        e_ld = (e_idx >= 0) ? mem[e_idx] : 4'd0;
        check((d == 0) ? "model_estado_a" : "model_estado_b", 32'(st), 32'(e_st));
        check((d == 0) ? "model_end_a" : "model_end_b", 32'(ad), 32'(e_ad));
        check((d == 0) ? "model_leds_a" : "model_leds_b", 32'(ld), 32'(e_ld));
        check((d == 0) ? "model_pronto_a" : "model_pronto_b", 32'(pr), 32'(e_pr));
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            compare_one(0, db_a, end_a, leds_a, pronto_a);
            compare_one(1, db_b, end_b, leds_b, pronto_b);
        end
    end

    // ---------------- directed playback with traces ----------------
    logic [3:0] tr_led_a [256];
    logic [3:0] tr_led_b [256];
    logic [3:0] tr_end_a [256];
    logic [3:0] tr_end_b [256];
    logic [3:0] tr_st_a  [256];
    logic [3:0] tr_st_b  [256];
    int fim_a, fim_b;

    // Called mid-cycle; edge 0 samples iniciar, trace index n is the state after edge n.
    task automatic play(input int budget, input bit hold, input int cancel_at,
                        input int chg_at, input logic [3:0] chg_val);
        for (int i = 0; i < 256; i++) begin
            tr_led_a[i] = '0; tr_led_b[i] = '0; tr_end_a[i] = '0;
            tr_end_b[i] = '0; tr_st_a[i]  = '0; tr_st_b[i]  = '0;
        end
        fim_a = -1;
        fim_b = -1;
        iniciar = 1'b1;
        @(posedge clock); #1;
        if (!hold) iniciar = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clock); #1;
            cancelar = 1'b0;
            tr_led_a[n] = leds_a; tr_led_b[n] = leds_b;
            tr_end_a[n] = end_a;  tr_end_b[n] = end_b;
            tr_st_a[n]  = db_a;   tr_st_b[n]  = db_b;
            if (pronto_a && fim_a < 0) fim_a = n;
            if (pronto_b && fim_b < 0) fim_b = n;
            if (n == cancel_at) cancelar = 1'b1;
            if (n == chg_at) limite = chg_val;
        end
        iniciar = 1'b0;
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; cancelar = 1'b0; limite = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_estado", 32'(db_a), 32'd0);
        check("reset_leds", 32'(leds_a), 32'd0);
        check("reset_end", 32'(end_a), 32'd0);
        check("reset_pronto", 32'(pronto_a), 32'd0);

        // Three entries at default timing.
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        limite = 4'd2;
        play(30, 1'b0, -1, -1, 4'd0);
        check("seq3_fim_edge", 32'(fim_a), 32'd24);
        check("seq3_fim_edge_b", 32'(fim_b), 32'd12);
        check("seq3_led_e0", 32'(tr_led_a[2]), 32'b0001);
        check("seq3_gap", 32'(tr_led_a[6]), 32'd0);
        check("seq3_led_e1", 32'(tr_led_a[10]), 32'b0010);
        check("seq3_led_e2", 32'(tr_led_a[18]), 32'b0100);

        // Single entry.
        mem[0] = 4'b1000;
        limite = 4'd0;
        play(12, 1'b0, -1, -1, 4'd0);
        check("one_fim_edge", 32'(fim_a), 32'd8);
        check("one_led", 32'(tr_led_a[2]), 32'b1000);
        check("one_end_fim", 32'(tr_end_a[8]), 32'd0);
        check("one_end_after", 32'(end_a), 32'd0);

        // Limit changed during second on-time has no effect.
        mem[0] = 4'b0001;
        limite = 4'd2;
        play(30, 1'b0, -1, 11, 4'd0);
        check("limchg_fim_edge", 32'(fim_a), 32'd24);
        check("limchg_led_e2", 32'(tr_led_a[18]), 32'b0100);

        // Cancel in the gap after entry 1, then replay from scratch.
        limite = 4'd2;
        play(40, 1'b0, 14, -1, 4'd0);
        check("cancel_in_apaga", 32'(tr_st_a[14]), 32'd4);
        check("cancel_estado", 32'(tr_st_a[15]), 32'd0);
        check("cancel_leds", 32'(tr_led_a[15]), 32'd0);
        check("cancel_end", 32'(tr_end_a[15]), 32'd0);
        check("cancel_no_pronto", 32'(fim_a), 32'hFFFF_FFFF);
        play(30, 1'b0, -1, -1, 4'd0);
        check("replay_fim_edge", 32'(fim_a), 32'd24);
        check("replay_led_e0", 32'(tr_led_a[2]), 32'b0001);

        // Asynchronous reset while 0100 is on display.
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        for (int n = 0; n < 30 && leds_a != 4'b0100; n++) begin
            @(posedge clock); #1;
        end
        check("pre_reset_leds", 32'(leds_a), 32'b0100);
        #1 reset = 1'b1;
        #1;
        check("async_rst_leds", 32'(leds_a), 32'd0);
        check("async_rst_end", 32'(end_a), 32'd0);
        check("async_rst_estado", 32'(db_a), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (8) begin
            @(posedge clock); #1;
        end
        check("post_rst_idle", 32'(db_a), 32'd0);

        // Full address range, iniciar held, 1/1 timing instance.
        for (int i = 0; i < 16; i++) mem[i] = 4'((i * 7 + 3) % 16);
        limite = 4'd15;
        play(70, 1'b1, -1, -1, 4'd0);
        check("full_fim_edge", 32'(fim_b), 32'd64);
        check("full_led_first", 32'(tr_led_b[2]), 32'd3);
        check("full_led_last", 32'(tr_led_b[62]), 32'd12);
        check("full_end_last", 32'(tr_end_b[64]), 32'd15);
        check("full_after_fim", 32'(tr_st_b[65]), 32'd0);
        check("full_restart", 32'(tr_st_b[66]), 32'd1);
        repeat (70) begin
            @(posedge clock); #1;
        end
        check("final_idle_a", 32'(db_a), 32'd0);
        check("final_idle_b", 32'(db_b), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
